// File: rtl/seg7_pkg.sv
// seg7_pkg: shared hex-to-segment table and polarity helpers for the scan driver
package seg7_pkg;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };
  localparam logic [6:0] SEG_DARK_AH = 7'b0000000;
  function automatic logic [6:0] seg_drive(input logic [6:0] seg_ah, input logic active_low);
    return active_low ? ~seg_ah : seg_ah;
  endfunction
endpackage

// File: rtl/seg7_hex_enc.sv
// seg7_hex_enc: combinational hex nibble to active-high {g..a} segment pattern
module seg7_hex_enc
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[hex_i];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex display scanner with blanking, blink and leading-zero suppression
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);
  localparam int IDX_W = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [6:0] SEG_OFF = seg_drive(SEG_DARK_AH, SEG_ACTIVE_LOW);
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [4*N_DIGITS-1:0] value_q, value_d;
  logic [N_DIGITS-1:0]   blank_q, blank_d;
  logic [N_DIGITS-1:0]   blink_q, blink_d;
  logic                  lz_q, lz_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLK_W-1:0]      blk_q, blk_d;
  logic                  phase_q, phase_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  fd_q, fd_d;
  logic                  tick, wrap, dark, zero_run;
  logic [N_DIGITS-1:0]   lz_sup, hot;
  logic [3:0]            nib;
  logic [6:0]            seg_ah;

  assign nib = value_q[{idx_q, 2'b00} +: 4];

  seg7_hex_enc u_enc (
    .hex_i(nib),
    .seg_o(seg_ah)
  );

  // Shadow capture plus prescaler, digit index and blink phase next-state
  always_comb begin
    value_d = load ? value : value_q;
    blank_d = load ? blank_mask : blank_q;
    blink_d = load ? blink_mask : blink_q;
    lz_d    = load ? lz_en : lz_q;
    tick    = pre_q == PRE_LAST;
    wrap    = tick && idx_q == IDX_LAST;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    idx_d   = !tick ? idx_q : wrap ? '0 : idx_q + 1'b1;
    blk_d   = !wrap ? blk_q : blk_q == BLK_LAST ? '0 : blk_q + 1'b1;
    phase_d = (wrap && blk_q == BLK_LAST) ? !phase_q : phase_q;
    fd_d    = wrap;
  end

  // A digit is suppressed while every nibble from the top down to it is zero; digit 0 never is
  always_comb begin
    lz_sup   = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zero_run  = zero_run & (value_q[4*i +: 4] == 4'h0);
      lz_sup[i] = lz_q & zero_run;
    end
  end

  // Drive pattern for the digit under the current index, dark digits fully off
  always_comb begin
    dark  = blank_q[idx_q] | (blink_q[idx_q] & ~phase_q) | lz_sup[idx_q];
    hot   = dark ? '0 : N_DIGITS'(1) << idx_q;
    seg_d = dark ? SEG_OFF : seg_drive(seg_ah, SEG_ACTIVE_LOW);
    an_d  = hot ^ AN_OFF;
  end

  // Shadow registers follow the load strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      blank_q <= '0;
      blink_q <= '0;
      lz_q    <= 1'b0;
    end else begin
      value_q <= value_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      lz_q    <= lz_d;
    end
  end

  // Scan timing: prescaler, digit index and blink frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
    end
  end

  // Registered display outputs and end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      fd_q  <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;
endmodule
